// File: rtl/alu_cmd_issuer.sv
// Byte-stream command front end for the ALU: assembles CC/DD frames, issues one
// ALU operation, and returns the 16-bit result (or an error byte) low byte first.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a frame header, other bytes dropped
// GET_A    | next byte is operand A
// GET_B    | next byte is operand B
// GET_FUN  | next byte carries the function code in bits [3:0]
// ISSUE    | ALU_EN high for this single cycle
// WAIT     | waiting for OUT_VALID, bounded by TIMEOUT cycles
// SEND_LO  | presenting result low byte until accepted
// SEND_HI  | presenting result high byte until accepted
// SEND_ERR | presenting ERR_CODE until accepted
module alu_cmd_issuer #(
  parameter int DATA_WIDTH = 8,
  parameter int OUT_WIDTH  = 2 * DATA_WIDTH,
  parameter int TIMEOUT    = 15,
  parameter logic [DATA_WIDTH-1:0] CMD_FULL  = 8'hCC,
  parameter logic [DATA_WIDTH-1:0] CMD_REUSE = 8'hDD,
  parameter logic [DATA_WIDTH-1:0] ERR_CODE  = 8'hEE
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] RX_DATA,
  input  logic                  RX_VALID,
  output logic [DATA_WIDTH-1:0] ALU_A,
  output logic [DATA_WIDTH-1:0] ALU_B,
  output logic [3:0]            ALU_FUN,
  output logic                  ALU_EN,
  input  logic [OUT_WIDTH-1:0]  ALU_OUT,
  input  logic                  OUT_VALID,
  output logic [DATA_WIDTH-1:0] TX_DATA,
  output logic                  TX_VALID,
  input  logic                  TX_READY,
  output logic                  BUSY,
  output logic                  ERR
);

  typedef enum logic [3:0] {
    IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT, SEND_LO, SEND_HI, SEND_ERR
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH-1:0] hi_byte;
  logic [7:0]            cnt;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      hi_byte  <= '0;
      cnt      <= '0;
      ALU_A    <= '0;
      ALU_B    <= '0;
      ALU_FUN  <= '0;
      ALU_EN   <= 1'b0;
      TX_DATA  <= '0;
      TX_VALID <= 1'b0;
      BUSY     <= 1'b0;
      ERR      <= 1'b0;
    end else begin
      ALU_EN <= 1'b0;
      ERR    <= 1'b0;
      case (state)
        IDLE: begin
          if (RX_VALID) begin
            if (RX_DATA == CMD_FULL) begin
              state <= GET_A;
              BUSY  <= 1'b1;
            end else if (RX_DATA == CMD_REUSE) begin
              state <= GET_FUN;
              BUSY  <= 1'b1;
            end
          end
        end
        GET_A: begin
          if (RX_VALID) begin
            a_reg <= RX_DATA;
            state <= GET_B;
          end
        end
        GET_B: begin
          if (RX_VALID) begin
            b_reg <= RX_DATA;
            state <= GET_FUN;
          end
        end
        GET_FUN: begin
          // ALU operand outputs load here so they are valid alongside ALU_EN
          if (RX_VALID) begin
            ALU_A   <= a_reg;
            ALU_B   <= b_reg;
            ALU_FUN <= RX_DATA[3:0];
            ALU_EN  <= 1'b1;
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (OUT_VALID) begin
            hi_byte  <= ALU_OUT[OUT_WIDTH-1:DATA_WIDTH];
            TX_DATA  <= ALU_OUT[DATA_WIDTH-1:0];
            TX_VALID <= 1'b1;
            state    <= SEND_LO;
          end else if (cnt == CNT_LAST) begin
            ERR      <= 1'b1;
            TX_DATA  <= ERR_CODE;
            TX_VALID <= 1'b1;
            state    <= SEND_ERR;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        SEND_LO: begin
          if (TX_READY) begin
            TX_DATA <= hi_byte;
            state   <= SEND_HI;
          end
        end
        SEND_HI, SEND_ERR: begin
          if (TX_READY) begin
            TX_DATA  <= '0;
            TX_VALID <= 1'b0;
            BUSY     <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          TX_VALID <= 1'b0;
          BUSY     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU operand/function interface: collects command frames from an 8-bit byte stream (UART RX side), drives A, B, ALU_FUN and ALU_EN into the ALU, and captures ALU_OUT on OUT_VALID.
- Returns the 16-bit result as two bytes, low byte first, on a valid/ready byte output (UART TX side).
- Sits between the UART bytes and the ALU in the final system. Includes a response timeout that returns an error code.

Parameters:
- DATA_WIDTH, 8, operand and byte width.
- OUT_WIDTH, 16, ALU result width; fixed at 2*DATA_WIDTH.
- TIMEOUT, 15, maximum cycles spent in WAIT before error; legal range 2..255.
- CMD_FULL, 8'hCC, frame header: CC, A, B, FUN.
- CMD_REUSE, 8'hDD, frame header: DD, FUN (reuses stored A/B).
- ERR_CODE, 8'hEE, byte sent on timeout.

Ports:
- CLK  in  1  system clock, rising edge.
- RST  in  1  synchronous, active-high reset.
- RX_DATA  in  8  incoming byte.
- RX_VALID  in  1  one-cycle byte strobe; no backpressure.
- ALU_A  out  DATA_WIDTH  operand A to ALU.
- ALU_B  out  DATA_WIDTH  operand B to ALU.
- ALU_FUN  out  4  function code to ALU.
- ALU_EN  out  1  one-cycle issue strobe.
- ALU_OUT  in  OUT_WIDTH  ALU result.
- OUT_VALID  in  1  ALU result valid.
- TX_DATA  out  8  outgoing byte.
- TX_VALID  out  1  TX_DATA valid.
- TX_READY  in  1  downstream accepts byte.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  one-cycle pulse on timeout.

Behaviour:
- Reset: all outputs 0. Stored operands A/B = 0. State = IDLE. Timeout counter = 0. Reset on any cycle aborts the operation in progress, with no partial TX.
- States: IDLE, GET_A, GET_B, GET_FUN, ISSUE, WAIT, SEND_LO, SEND_HI, SEND_ERR.
- IDLE:
  - RX byte == CMD_FULL -> GET_A.
  - RX byte == CMD_REUSE -> GET_FUN.
  - Any other byte is dropped.
- GET_A: on RX_VALID, store byte as A -> GET_B.
- GET_B: on RX_VALID, store byte as B -> GET_FUN.
- GET_FUN: on RX_VALID, latch byte[3:0] as FUN (byte[7:4] ignored) -> ISSUE.
- No inter-byte timeout in GET_* states; a frame waits indefinitely for its next byte.
- ISSUE, one cycle:
  - ALU_EN = 1; ALU_A/ALU_B/ALU_FUN = stored values -> WAIT.
  - ALU_A/B/FUN remain driven with stored values until the next ISSUE.
  - Latency: FUN byte sampled at edge t, ALU_EN high during cycle t+1.
- WAIT:
  - Counter starts at 0 on entry and increments each cycle.
  - OUT_VALID = 1: capture ALU_OUT into the result register -> SEND_LO.
  - Otherwise, when the counter reaches TIMEOUT-1 -> SEND_ERR.
  - OUT_VALID on the same cycle as expiry: the result wins.
- OUT_VALID outside WAIT is ignored.
- SEND_LO: TX_VALID = 1, TX_DATA = result[7:0]. Hold both stable until TX_READY is sampled high -> SEND_HI.
- SEND_HI: same rule with result[15:8] -> IDLE. TX_VALID drops the cycle after the handshake.
- SEND_ERR:
  - ERR pulses high for the first cycle in SEND_ERR only.
  - TX_DATA = ERR_CODE, held until TX_READY -> IDLE.
  - Stored A/B are kept.
- RX_VALID during ISSUE, WAIT or SEND_*: byte dropped, with no effect on state or stored values.
- TX_READY while TX_VALID = 0 is ignored.
- Back-to-back frames: a header byte arriving the cycle after returning to IDLE is accepted.

Test Plan:
1. RX CC,05,03,00; model ALU returns OUT_VALID with ALU_OUT=0x0008 one cycle after ALU_EN -> ALU_EN high exactly one cycle with A=05, B=03, FUN=0; TX bytes 0x08 then 0x00; BUSY falls after the second handshake.
2. After scenario 1, RX DD,F2 -> ALU_A=05, ALU_B=03, ALU_FUN=2 reused; model result 0x000F -> TX 0x0F, 0x00.
3. RX CC,01,01,04 with OUT_VALID held low -> exactly 15 WAIT cycles, ERR one-cycle pulse, single TX byte 0xEE, no result bytes; return to IDLE.
4. Result 0x1234, TX_READY low for 5 cycles -> TX_VALID high and TX_DATA=0x34 stable throughout; then 0x34, 0x12 accepted on successive TX_READY cycles.
5. RST high during SEND_HI -> all outputs 0 at the next edge; following DD,00 issues A=00, B=00.
6. RX 0x41, 0x7E in IDLE -> ignored. RX 0x55 during WAIT -> dropped. OUT_VALID pulse while in IDLE -> no TX; a subsequent normal frame completes correctly.
